// File: rtl/hdc_frame_assembler_pkg.sv
// Shared constants, state encoding and helpers for the HDC frame assembler.
package hdc_frame_assembler_pkg;

    localparam int CHANNEL_WIDTH  = 16;
    localparam int INPUT_CHANNELS = 64;
    localparam int MODE_WIDTH     = 2;
    localparam int LABEL_WIDTH    = 5;

    // Smallest r with 2**r >= n; never below 1 so index ports stay non-empty.
    function automatic int ceilLog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    typedef enum logic {
        SYNC = 1'b0,
        FILL = 1'b1
    } state_e;

endpackage

// File: rtl/hdc_frame_outreg.sv
// Output holding register: presents one frame on a valid/ready port and
// takes a new frame whenever the assembler completes one.
module hdc_frame_outreg #(
    parameter int FW = 1024,
    parameter int MW = 2,
    parameter int LW = 5
) (
    input  logic          Clk_CI,
    input  logic          Reset_RI,
    input  logic          Load_SI,
    input  logic [0:FW-1] Frame_DI,
    input  logic [MW-1:0] Mode_DI,
    input  logic [LW-1:0] Label_DI,
    input  logic          Ready_SI,
    output logic          Valid_SO,
    output logic [0:FW-1] Frame_DO,
    output logic [MW-1:0] Mode_DO,
    output logic [LW-1:0] Label_DO
);

    logic          valid_q, valid_d;
    logic [0:FW-1] frame_q, frame_d;
    logic [MW-1:0] mode_q, mode_d;
    logic [LW-1:0] label_q, label_d;

    // A load wins over a handshake, so a frame completing in the handshake
    // cycle replaces the departing one and valid stays high. The upstream
    // only loads when the register is empty or draining this cycle.
    always_comb begin
        valid_d = valid_q;
        frame_d = frame_q;
        mode_d  = mode_q;
        label_d = label_q;
        if (Load_SI) begin
            valid_d = 1'b1;
            frame_d = Frame_DI;
            mode_d  = Mode_DI;
            label_d = Label_DI;
        end else if (valid_q && Ready_SI) begin
            valid_d = 1'b0;
        end
    end

    // Holding flops; data only moves on a load, so it is stable while stalled.
    always_ff @(posedge Clk_CI or posedge Reset_RI) begin
        if (Reset_RI) begin
            valid_q <= 1'b0;
            frame_q <= '0;
            mode_q  <= '0;
            label_q <= '0;
        end else begin
            valid_q <= valid_d;
            frame_q <= frame_d;
            mode_q  <= mode_d;
            label_q <= label_d;
        end
    end

    assign Valid_SO = valid_q;
    assign Frame_DO = frame_q;
    assign Mode_DO  = mode_q;
    assign Label_DO = label_q;

endmodule

// File: rtl/hdc_frame_assembler.sv
// Packs per-channel ADC samples into full frames with index checking,
// tag capture at channel 0, drop counting and a double-buffered output.
module hdc_frame_assembler #(
    parameter int CHANNEL_WIDTH  = hdc_frame_assembler_pkg::CHANNEL_WIDTH,
    parameter int INPUT_CHANNELS = hdc_frame_assembler_pkg::INPUT_CHANNELS,
    parameter int MODE_WIDTH     = hdc_frame_assembler_pkg::MODE_WIDTH,
    parameter int LABEL_WIDTH    = hdc_frame_assembler_pkg::LABEL_WIDTH,
    parameter int IDX_WIDTH      = hdc_frame_assembler_pkg::ceilLog2(INPUT_CHANNELS)
) (
    input  logic                                    Clk_CI,
    input  logic                                    Reset_RI,
    input  logic                                    SampleValid_SI,
    output logic                                    SampleReady_SO,
    input  logic [CHANNEL_WIDTH-1:0]                Sample_DI,
    input  logic [IDX_WIDTH-1:0]                    ChannelIdx_DI,
    input  logic [MODE_WIDTH-1:0]                   ModeIn_SI,
    input  logic [LABEL_WIDTH-1:0]                  LabelIn_DI,
    input  logic                                    Flush_SI,
    output logic                                    FrameValid_SO,
    input  logic                                    FrameReady_SI,
    output logic [0:CHANNEL_WIDTH*INPUT_CHANNELS-1] Frame_DO,
    output logic [MODE_WIDTH-1:0]                   ModeOut_SO,
    output logic [LABEL_WIDTH-1:0]                  LabelOut_DO,
    output logic [7:0]                              DropCount_DO
);

    import hdc_frame_assembler_pkg::*;

    localparam int                   FW       = CHANNEL_WIDTH * INPUT_CHANNELS;
    localparam int                   LAST_OFF = (INPUT_CHANNELS - 1) * CHANNEL_WIDTH;
    localparam logic [IDX_WIDTH-1:0] LAST     = IDX_WIDTH'(INPUT_CHANNELS - 1);

    state_e                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   cnt_q, cnt_d;
    logic [0:FW-1]          asm_q, asm_d;
    logic [MODE_WIDTH-1:0]  mode_q, mode_d;
    logic [LABEL_WIDTH-1:0] label_q, label_d;
    logic [7:0]             drop_q, drop_d;
    logic [0:FW-1]          frame_new;
    logic                   load;
    logic                   accept;
    logic                   idx_zero;

    // Only the final sample needs the output register; it stalls when a
    // held frame is not leaving this cycle. Flush always blocks the input.
    assign SampleReady_SO = !Flush_SI &&
                            !(state_q == FILL && cnt_q == LAST &&
                              FrameValid_SO && !FrameReady_SI);
    assign accept   = SampleValid_SI && SampleReady_SO;
    assign idx_zero = (ChannelIdx_DI == '0);

    // Frame FSM, slot writes, tag capture and saturating drop counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        mode_d  = mode_q;
        label_d = label_q;
        drop_d  = drop_q;
        load    = 1'b0;

        // The last slot bypasses the assembly register straight to the output.
        frame_new = asm_q;
        frame_new[LAST_OFF +: CHANNEL_WIDTH] = Sample_DI;

        if (Flush_SI) begin
            state_d = SYNC;
            cnt_d   = '0;
        end else if (accept) begin
            if (state_q == SYNC) begin
                if (idx_zero) begin
                    asm_d[0 +: CHANNEL_WIDTH] = Sample_DI;
                    mode_d  = ModeIn_SI;
                    label_d = LabelIn_DI;
                    cnt_d   = IDX_WIDTH'(1);
                    state_d = FILL;
                end
            end else if (ChannelIdx_DI == cnt_q) begin
                if (cnt_q == LAST) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = SYNC;
                end else begin
                    asm_d[int'(ChannelIdx_DI) * CHANNEL_WIDTH +: CHANNEL_WIDTH] = Sample_DI;
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                drop_d = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
                if (idx_zero) begin
                    // Out-of-order channel 0 restarts the frame in place.
                    asm_d[0 +: CHANNEL_WIDTH] = Sample_DI;
                    mode_d  = ModeIn_SI;
                    label_d = LabelIn_DI;
                    cnt_d   = IDX_WIDTH'(1);
                end else begin
                    cnt_d   = '0;
                    state_d = SYNC;
                end
            end
        end
    end

    // Assembly-side state flops.
    always_ff @(posedge Clk_CI or posedge Reset_RI) begin
        if (Reset_RI) begin
            state_q <= SYNC;
            cnt_q   <= '0;
            asm_q   <= '0;
            mode_q  <= '0;
            label_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            mode_q  <= mode_d;
            label_q <= label_d;
            drop_q  <= drop_d;
        end
    end

    assign DropCount_DO = drop_q;

    hdc_frame_outreg #(
        .FW (FW),
        .MW (MODE_WIDTH),
        .LW (LABEL_WIDTH)
    ) u_outreg (
        .Clk_CI   (Clk_CI),
        .Reset_RI (Reset_RI),
        .Load_SI  (load),
        .Frame_DI (frame_new),
        .Mode_DI  (mode_q),
        .Label_DI (label_q),
        .Ready_SI (FrameReady_SI),
        .Valid_SO (FrameValid_SO),
        .Frame_DO (Frame_DO),
        .Mode_DO  (ModeOut_SO),
        .Label_DO (LabelOut_DO)
    );

endmodule
